lc2k_data_mem: RTL and testbench

Parametrised, synchronous data memory for the LC2K CPU, replacing the combinational word-array data memory. It serves `lw` and `sw` from the MEM stage through a valid/ready request port and a one-cycle response pulse. It adds three things the old block lacked: configurable wait states, out-of-range address detection, and a hardware zero-initialisation sweep after reset. This lets the multi-cycle and pipelined cores stall on memory instead of assuming zero-delay access.

---
 rtl/lc2k_data_mem_pkg.sv | 19 +
 rtl/lc2k_data_mem_if.sv | 44 ++++
 rtl/lc2k_data_mem_ram.sv | 28 ++
 rtl/lc2k_data_mem.sv | 187 ++++++++++++++++++
 tb/tb_lc2k_data_mem.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/lc2k_data_mem_pkg.sv
// Shared types and constants for the LC2K synchronous data memory.
package lc2k_mem_pkg;

   // Width of the wait-state down-counter; holds WAIT_CYCLES-1 for 0..15.
   localparam int WAIT_CNT_W = 4;

   // Native LC2K machine word width.
   localparam int LC2K_WORD_W = 32;

   // Controller states: zero-fill sweep, ready for a request,
   // wait-state countdown, response presentation.
   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } mem_state_t;

endpackage

// File: rtl/lc2k_data_mem_if.sv
// Request/response bus between the LC2K MEM stage and the data memory.
// The CPU side is the master; the memory is the slave.
interface lc2k_data_mem_if
   import lc2k_mem_pkg::*;
#(
   parameter int ADDR_W = LC2K_WORD_W,
   parameter int DATA_W = LC2K_WORD_W
);

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic              init_done;

   modport master (
      output req_valid,
      output req_write,
      output req_addr,
      output req_wdata,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  resp_err,
      input  init_done
   );

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_wdata,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output resp_err,
      output init_done
   );

endinterface

// File: rtl/lc2k_data_mem_ram.sv
// Single-port synchronous RAM with a registered read port. The array has
// no reset; the controller clears it with a sweep after every reset.
module lc2k_sp_ram
   import lc2k_mem_pkg::*;
#(
   parameter int DATA_W = LC2K_WORD_W,
   parameter int DEPTH  = 64,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write on request and register the addressed word every cycle
   // (read-before-write on a simultaneous access).
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/lc2k_data_mem.sv
// LC2K data memory: valid/ready request port, configurable wait states,
// out-of-range detection and a zero-fill sweep after reset. The access is
// performed on the edge that enters RESP; the response lasts one cycle.
module lc2k_data_mem
   import lc2k_mem_pkg::*;
#(
   parameter int DATA_W      = LC2K_WORD_W,
   parameter int DEPTH       = 64,
   parameter int ADDR_W      = LC2K_WORD_W,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   lc2k_data_mem_if.slave   bus
);

   localparam int                    IDX_W      = $clog2(DEPTH);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(DEPTH - 1);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD  =
      WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [ADDR_W:0]       ADDR_LIMIT = (ADDR_W + 1)'(DEPTH);
   localparam logic                  NO_WAIT    = (WAIT_CYCLES == 0);

   mem_state_t             state;
   logic [IDX_W-1:0]       idx;
   logic [WAIT_CNT_W-1:0]  wait_cnt;
   logic                   init_done_q;

   logic                   lat_write;
   logic [ADDR_W-1:0]      lat_addr;
   logic [DATA_W-1:0]      lat_wdata;

   logic                   resp_valid_q;
   logic                   resp_err_q;
   logic                   resp_load_q;
   logic [DATA_W-1:0]      resp_rdata_q;

   logic                   accept;
   logic                   access_now;
   logic                   acc_write;
   logic [ADDR_W-1:0]      acc_addr;
   logic [DATA_W-1:0]      acc_wdata;
   logic                   acc_in_range;

   logic                   ram_we;
   logic [IDX_W-1:0]       ram_addr;
   logic [DATA_W-1:0]      ram_wdata;
   logic [DATA_W-1:0]      ram_rdata;

   // Select the request being executed: with no wait states the access
   // happens on the accept edge itself, so the live bus feeds it directly;
   // otherwise the latched copy is used and later bus changes are ignored.
   always_comb begin
      accept       = (state == IDLE) && bus.req_valid;
      acc_write    = lat_write;
      acc_addr     = lat_addr;
      acc_wdata    = lat_wdata;
      if (state == IDLE) begin
         acc_write = bus.req_write;
         acc_addr  = bus.req_addr;
         acc_wdata = bus.req_wdata;
      end
      acc_in_range = ({1'b0, acc_addr} < ADDR_LIMIT);
      access_now   = rst_n &&
                     ((accept && NO_WAIT) ||
                      ((state == WAIT) && (wait_cnt == '0)));
   end

   // RAM port mux: the zero-fill sweep owns the write port in INIT,
   // otherwise only an in-range store on its access edge may write.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = acc_addr[IDX_W-1:0];
      ram_wdata = acc_wdata;
      if (state == INIT) begin
         ram_we    = rst_n;
         ram_addr  = idx;
         ram_wdata = '0;
      end else if (access_now) begin
         ram_we = acc_write && acc_in_range;
      end
   end

   lc2k_sp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Controller FSM with the sweep index and the wait-state countdown.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= INIT;
         idx         <= '0;
         wait_cnt    <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               idx <= idx + IDX_W'(1);
               if (idx == IDX_LAST) begin
                  idx         <= '0;
                  init_done_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            IDLE: begin
               if (accept) begin
                  if (NO_WAIT) begin
                     state <= RESP;
                  end else begin
                     wait_cnt <= WAIT_LOAD;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

   // Capture the request on acceptance so the bus may change while busy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         lat_write <= bus.req_write;
         lat_addr  <= bus.req_addr;
         lat_wdata <= bus.req_wdata;
      end
   end

   // Response registers: a one-cycle valid pulse on the access edge, plus
   // error/load flags and a held copy of the read data for after the pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_load_q  <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= access_now;
         if (access_now) begin
            resp_err_q  <= !acc_in_range;
            resp_load_q <= !acc_write && acc_in_range;
         end
         if (resp_valid_q) begin
            resp_rdata_q <= resp_load_q ? ram_rdata : '0;
         end
      end
   end

   // The RAM output is only valid during the response cycle; after that
   // the held copy keeps the data stable until the next response.
   always_comb begin
      bus.resp_rdata = resp_rdata_q;
      if (resp_valid_q) begin
         bus.resp_rdata = resp_load_q ? ram_rdata : '0;
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_lc2k_data_mem.sv
// Directed bench for lc2k_data_mem: one instance with two wait states and
// one with none, sharing clock and reset.
module tb_lc2k_data_mem;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   lc2k_data_mem_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
   lc2k_data_mem_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

   lc2k_data_mem #(
      .DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(2)
   ) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   lc2k_data_mem #(
      .DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(0)
   ) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Wait for the zero-fill sweep of dut2 after reset release; returns the
   // number of falling edges seen until init_done.
   task automatic waitInit(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus2.init_done !== 1'b1 && n < 200);
   endtask

   // Issue one request to dut2, scramble the bus while it is busy, and
   // return the response plus its latency in falling edges after accept.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                input logic [31:0] data,
                                output logic [31:0] rdata, output logic err,
                                output int lat);
      int guard;
      @(negedge clk);
      guard = 0;
      while (bus2.req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("ready_before_req", {31'b0, bus2.req_ready}, 32'd1);
      bus2.req_valid = 1'b1;
      bus2.req_write = wr;
      bus2.req_addr  = addr;
      bus2.req_wdata = data;
      @(posedge clk);
      #1;
      bus2.req_valid = 1'b0;
      bus2.req_write = ~wr;
      bus2.req_addr  = ~addr;
      bus2.req_wdata = ~data;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (bus2.resp_valid !== 1'b1 && lat < 20);
      rdata = bus2.resp_rdata;
      err   = bus2.resp_err;
      @(negedge clk);
      checkOutput("pulse_width", {31'b0, bus2.resp_valid}, 32'd0);
   endtask

   // Directed sequence.
   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          n;
      logic        saw;
      logic        exp_v;

      bus2.req_valid = 1'b0; bus2.req_write = 1'b0;
      bus2.req_addr  = '0;   bus2.req_wdata = '0;
      bus0.req_valid = 1'b0; bus0.req_write = 1'b0;
      bus0.req_addr  = '0;   bus0.req_wdata = '0;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready",      {31'b0, bus2.req_ready},  32'd0);
      checkOutput("rst_resp_valid", {31'b0, bus2.resp_valid}, 32'd0);
      checkOutput("rst_resp_rdata", bus2.resp_rdata,          32'd0);
      checkOutput("rst_resp_err",   {31'b0, bus2.resp_err},   32'd0);
      checkOutput("rst_init_done",  {31'b0, bus2.init_done},  32'd0);
      checkOutput("rst_init_done0", {31'b0, bus0.init_done},  32'd0);

      rst_n = 1'b1;
      waitInit(n);
      checkOutput("init_latency",   n,                        32'd64);
      checkOutput("init_ready",     {31'b0, bus2.req_ready},  32'd1);
      checkOutput("init_done0",     {31'b0, bus0.init_done},  32'd1);

      applyStimulus(1'b1, 32'd7, 32'd5, rd, er, lat);
      checkOutput("sw7_latency", lat, 32'd3);
      checkOutput("sw7_err",     {31'b0, er}, 32'd0);
      checkOutput("sw7_rdata",   rd, 32'd0);

      applyStimulus(1'b0, 32'd7, 32'd0, rd, er, lat);
      checkOutput("lw7_latency", lat, 32'd3);
      checkOutput("lw7_rdata",   rd, 32'd5);
      checkOutput("lw7_err",     {31'b0, er}, 32'd0);
      checkOutput("lw7_held",    bus2.resp_rdata, 32'd5);

      applyStimulus(1'b1, 32'd64, 32'h0000_DEAD, rd, er, lat);
      checkOutput("sw64_err",    {31'b0, er}, 32'd1);
      checkOutput("sw64_rdata",  rd, 32'd0);

      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd0, rd, er, lat);
      checkOutput("lwneg_err",   {31'b0, er}, 32'd1);
      checkOutput("lwneg_rdata", rd, 32'd0);

      applyStimulus(1'b0, 32'd0, 32'd0, rd, er, lat);
      checkOutput("lw0_rdata",   rd, 32'd0);
      checkOutput("lw0_err",     {31'b0, er}, 32'd0);

      applyStimulus(1'b1, 32'd12, 32'h0000_CAFE, rd, er, lat);
      checkOutput("sw12_err",    {31'b0, er}, 32'd0);
      applyStimulus(1'b0, 32'd12, 32'd0, rd, er, lat);
      checkOutput("lw12_rdata",  rd, 32'h0000_CAFE);

      applyStimulus(1'b1, 32'd63, 32'h1234_5678, rd, er, lat);
      checkOutput("sw63_err",    {31'b0, er}, 32'd0);
      applyStimulus(1'b0, 32'd63, 32'd0, rd, er, lat);
      checkOutput("lw63_rdata",  rd, 32'h1234_5678);
      checkOutput("lw63_err",    {31'b0, er}, 32'd0);

      applyStimulus(1'b0, 32'd64, 32'd0, rd, er, lat);
      checkOutput("lw64_err",    {31'b0, er}, 32'd1);

      // Reset while a store sits in WAIT.
      @(negedge clk);
      checkOutput("midop_ready", {31'b0, bus2.req_ready}, 32'd1);
      bus2.req_valid = 1'b1;
      bus2.req_write = 1'b1;
      bus2.req_addr  = 32'd3;
      bus2.req_wdata = 32'd9;
      @(posedge clk);
      #1;
      bus2.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      saw = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus2.resp_valid === 1'b1) saw = 1'b1;
      end
      checkOutput("midop_no_resp",  {31'b0, saw},            32'd0);
      checkOutput("midop_init_low", {31'b0, bus2.init_done}, 32'd0);
      rst_n = 1'b1;
      waitInit(n);
      checkOutput("reinit_latency", n, 32'd64);

      applyStimulus(1'b0, 32'd3, 32'd0, rd, er, lat);
      checkOutput("lw3_after_rst",  rd, 32'd0);
      applyStimulus(1'b0, 32'd7, 32'd0, rd, er, lat);
      checkOutput("lw7_after_rst",  rd, 32'd0);
      applyStimulus(1'b0, 32'd12, 32'd0, rd, er, lat);
      checkOutput("lw12_after_rst", rd, 32'd0);

      // Zero wait states: single store, then a held stream of loads.
      @(negedge clk);
      checkOutput("zw_ready_idle", {31'b0, bus0.req_ready}, 32'd1);
      bus0.req_valid = 1'b1;
      bus0.req_write = 1'b1;
      bus0.req_addr  = 32'd5;
      bus0.req_wdata = 32'h0000_0077;
      @(posedge clk);
      #1;
      bus0.req_valid = 1'b0;
      bus0.req_addr  = 32'd6;
      bus0.req_wdata = 32'h0000_0BAD;
      @(negedge clk);
      checkOutput("zw_sw_valid", {31'b0, bus0.resp_valid}, 32'd1);
      checkOutput("zw_sw_err",   {31'b0, bus0.resp_err},   32'd0);
      @(negedge clk);
      checkOutput("zw_sw_pulse", {31'b0, bus0.resp_valid}, 32'd0);

      bus0.req_valid = 1'b1;
      bus0.req_write = 1'b0;
      bus0.req_addr  = 32'd5;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         exp_v = (i % 2 == 1);
         checkOutput("zw_valid", {31'b0, bus0.resp_valid}, {31'b0, exp_v});
         checkOutput("zw_ready", {31'b0, bus0.req_ready},  {31'b0, !exp_v});
         if (exp_v) begin
            checkOutput("zw_rdata", bus0.resp_rdata, 32'h0000_0077);
         end
      end
      bus0.req_valid = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
